soc_system_timer_multi: RTL

//  Parametrised multi-channel interval timer; Avalon-MM slave, one independent down-counter per channel.

---
 rtl/soc_system_timer_multi_pkg.sv | 29 ++
 rtl/soc_timer_channel.sv | 124 ++++++++++++
 rtl/soc_system_timer_multi.sv | 76 +++++++
 3 files changed

// File: rtl/soc_system_timer_multi_pkg.sv
// Shared definitions for the multi-channel interval timer: register
// offsets, CONTROL bit positions and the STATUS word packing.
package soc_system_timer_multi_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_PRESCALE = 3'd3,
    REG_SNAP     = 3'd4,
    REG_COUNT    = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_e;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int MISSED_W = 8;
  localparam logic [MISSED_W-1:0] MISSED_MAX = '1;

  function automatic logic [31:0] status_word(input logic [MISSED_W-1:0] missed,
                                              input logic run, input logic to);
    return {16'b0, missed, 6'b0, run, to};
  endfunction

endpackage

// File: rtl/soc_timer_channel.sv
// One timer channel: config registers, prescaler, down-counter,
// RUN/TO/MISSED flags and the count snapshot.
module soc_timer_channel
  import soc_system_timer_multi_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 16,
  parameter logic [31:0] RST_PERIOD = 32'h0003_D08F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_prescale,
  input  logic        wr_snap,
  input  logic [31:0] wdata,
  input  reg_e        rd_sel,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]          ctrl;
  logic [CNT_W-1:0]    period;
  logic [PRE_W-1:0]    prescale;
  logic [CNT_W-1:0]    snap;
  logic [CNT_W-1:0]    count;
  logic [PRE_W-1:0]    pre_cnt;
  logic [MISSED_W-1:0] missed;
  logic                to;
  logic                run;
  logic                reload_pend;

  logic tick, timeout_event, start_wr, stop_wr, clr_wr;

  assign tick          = run & (pre_cnt == prescale);
  assign timeout_event = tick & (count == '0);
  assign start_wr      = wr_control & wdata[CTRL_START];
  assign stop_wr       = wr_control & wdata[CTRL_STOP];
  assign clr_wr        = wr_status & wdata[0];

  // Software-visible configuration registers and the snapshot latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      period   <= CNT_W'(RST_PERIOD);
      prescale <= '0;
      snap     <= '0;
    end else begin
      if (wr_control)  ctrl     <= wdata[3:0];
      if (wr_period)   period   <= wdata[CNT_W-1:0];
      if (wr_prescale) prescale <= wdata[PRE_W-1:0];
      if (wr_snap)     snap     <= count;
    end
  end

  // Prescaler: held at zero while stopped so every START begins a full tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (wr_prescale || !run || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Down-counter; a PERIOD write defers the reload by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= CNT_W'(RST_PERIOD);
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= wr_period;
      if (reload_pend || timeout_event) begin
        count <= period;
      end else if (tick) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // RUN/TO/MISSED flags; a timeout outranks a same-cycle W1C on TO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run    <= 1'b0;
      to     <= 1'b0;
      missed <= '0;
    end else begin
      if (start_wr) begin
        run <= 1'b1;
      end else if (stop_wr || wr_period || (timeout_event && !ctrl[CTRL_CONT])) begin
        run <= 1'b0;
      end
      if (timeout_event) begin
        to <= 1'b1;
      end else if (clr_wr) begin
        to <= 1'b0;
      end
      if (clr_wr) begin
        missed <= '0;
      end else if (timeout_event && to && (missed != MISSED_MAX)) begin
        missed <= missed + MISSED_W'(1);
      end
    end
  end

  // Read word for the selected register, zero-extended to 32 bits.
  always_comb begin
    rdata = '0;
    case (rd_sel)
      REG_STATUS:   rdata = status_word(missed, run, to);
      REG_CONTROL:  rdata = {28'b0, ctrl};
      REG_PERIOD:   rdata = 32'(period);
      REG_PRESCALE: rdata = 32'(prescale);
      REG_SNAP:     rdata = 32'(snap);
      REG_COUNT:    rdata = 32'(count);
      default:      rdata = '0;
    endcase
  end

  assign irq = to & ctrl[CTRL_ITO];

endmodule

// File: rtl/soc_system_timer_multi.sv
// Multi-channel interval timer, Avalon-MM slave. Address decode, a
// registered read mux and the IRQ OR around NUM_CH channel instances.
module soc_system_timer_multi
  import soc_system_timer_multi_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 16,
  parameter logic [31:0] RST_PERIOD = 32'h0003_D08F,
  localparam int         AW         = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  logic [31:0] ch_idx;
  reg_e        reg_sel;
  logic        wr_en;
  logic [31:0] ch_rdata [NUM_CH];
  logic [31:0] rd_mux;
  logic        unused_read_n;

  // Channel index is everything above the 3-bit register offset.
  assign ch_idx        = 32'(address) >> 3;
  assign reg_sel       = reg_e'(address[2:0]);
  assign wr_en         = chipselect & ~write_n;
  assign unused_read_n = read_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en & (ch_idx == 32'(g));

    soc_timer_channel #(
      .CNT_W      (CNT_W),
      .PRE_W      (PRE_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_status   (ch_wr && (reg_sel == REG_STATUS)),
      .wr_control  (ch_wr && (reg_sel == REG_CONTROL)),
      .wr_period   (ch_wr && (reg_sel == REG_PERIOD)),
      .wr_prescale (ch_wr && (reg_sel == REG_PRESCALE)),
      .wr_snap     (ch_wr && (reg_sel == REG_SNAP)),
      .wdata       (writedata),
      .rd_sel      (reg_sel),
      .rdata       (ch_rdata[g]),
      .irq         (irq_vec[g])
    );
  end

  // Select the addressed channel's word; absent channels read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) rd_mux = ch_rdata[i];
    end
  end

  // Read data is always registered, independent of read_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |irq_vec;

endmodule
